// File: rtl/cache_refill_controller_pkg.sv
// Constants, types and address helpers shared by the refill controller, cache and main memory.
package cache_refill_controller_pkg;

    localparam int unsigned ADDR_W          = 15;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned WORDS_PER_LINE  = 4;
    localparam int unsigned OFFSET_W        = 2;
    localparam int unsigned BLK_W           = ADDR_W - OFFSET_W;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [BLK_W-1:0]    blk_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCollect,
        StDone
    } state_e;

    function automatic blk_t blk_of(input addr_t addr);
        return addr[ADDR_W-1:OFFSET_W];
    endfunction

    function automatic addr_t line_addr_of(input blk_t blk);
        return {blk, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_controller_if.sv
// Cache-side and memory-side signals of the refill controller; master is the controller's view.
interface cache_refill_controller_if;
    import cache_refill_controller_pkg::*;

    logic  miss_req;
    addr_t miss_addr;
    logic  ready;
    logic  line_valid;
    addr_t line_addr;
    data_t line_word0;
    data_t line_word1;
    data_t line_word2;
    data_t line_word3;
    logic  refill_err;
    logic  mm_rd;
    addr_t mm_addr;
    data_t mm_rdata;
    logic  mm_rvalid;

    modport master (
        input  miss_req, miss_addr, mm_rdata, mm_rvalid,
        output ready, line_valid, line_addr, line_word0, line_word1, line_word2, line_word3,
        output refill_err, mm_rd, mm_addr
    );

    modport slave (
        output miss_req, miss_addr, mm_rdata, mm_rvalid,
        input  ready, line_valid, line_addr, line_word0, line_word1, line_word2, line_word3,
        input  refill_err, mm_rd, mm_addr
    );

endinterface

// File: rtl/cache_line_buffer.sv
// Four-word line register file: one indexed write port, all words readable in parallel.
module cache_line_buffer
    import cache_refill_controller_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    we_i,
    input  offset_t idx_i,
    input  data_t   wdata_i,
    output data_t   word0_o,
    output data_t   word1_o,
    output data_t   word2_o,
    output data_t   word3_o
);

    data_t mem_q [WORDS_PER_LINE];
    data_t mem_d [WORDS_PER_LINE];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[idx_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        word0_o = mem_q[0];
        word1_o = mem_q[1];
        word2_o = mem_q[2];
        word3_o = mem_q[3];
    end

endmodule

// File: rtl/cache_refill_controller.sv
// Cache line refill controller: accepts a miss, issues four word reads, assembles the line
// and pulses line_valid, or pulses refill_err when memory stops responding.
module cache_refill_controller
    import cache_refill_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                       clk,
    input logic                       rst,
    cache_refill_controller_if.master bus
);

    localparam int unsigned    WdW        = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast     = WdW'(TIMEOUT - 1);
    localparam offset_t        LastOffset = offset_t'(WORDS_PER_LINE - 1);

    state_e         state_q, state_d;
    blk_t           blk_q, blk_d;
    offset_t        issue_cnt_q, issue_cnt_d;
    offset_t        recv_cnt_q, recv_cnt_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    addr_t          line_addr_q, line_addr_d;

    logic  accept;
    logic  active;
    logic  capture;
    logic  last_word;
    logic  expire;
    data_t word0, word1, word2, word3;

    always_comb begin
        accept    = (state_q == StIdle) && !err_q && bus.miss_req;
        active    = (state_q == StIssue) || (state_q == StCollect);
        capture   = active && bus.mm_rvalid;
        last_word = capture && (recv_cnt_q == LastOffset);
        // A response arriving in the expiry cycle rescues the refill.
        expire    = active && !bus.mm_rvalid && (wd_q == WdLast);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (expire) begin
                    state_d = StIdle;
                end else if (last_word) begin
                    state_d = StDone;
                end else if (issue_cnt_q == LastOffset) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (expire) begin
                    state_d = StIdle;
                end else if (last_word) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        bus.ready      = (state_q == StIdle) && !err_q;
        bus.mm_rd      = (state_q == StIssue);
        bus.mm_addr    = (state_q == StIssue) ? {blk_q, issue_cnt_q} : '0;
        bus.line_valid = (state_q == StDone);
        bus.line_addr  = line_addr_q;
        bus.refill_err = err_q;
        bus.line_word0 = word0;
        bus.line_word1 = word1;
        bus.line_word2 = word2;
        bus.line_word3 = word3;
    end

    always_comb begin
        blk_d       = accept ? blk_of(bus.miss_addr) : blk_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        wd_d        = wd_q;
        if (accept) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            wd_d        = '0;
        end else begin
            if (state_q == StIssue) begin
                issue_cnt_d = issue_cnt_q + offset_t'(1);
            end
            if (capture) begin
                recv_cnt_d = recv_cnt_q + offset_t'(1);
                wd_d       = '0;
            end else if (active) begin
                wd_d = wd_q + WdW'(1);
            end
        end
        err_d = expire;
        // The previous line's address stays visible until the new line starts landing.
        line_addr_d = (capture && (recv_cnt_q == '0)) ? line_addr_of(blk_q) : line_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q       <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            line_addr_q <= '0;
        end else begin
            blk_q       <= blk_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            line_addr_q <= line_addr_d;
        end
    end

    cache_line_buffer u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .we_i    (capture),
        .idx_i   (recv_cnt_q),
        .wdata_i (bus.mm_rdata),
        .word0_o (word0),
        .word1_o (word1),
        .word2_o (word2),
        .word3_o (word3)
    );

endmodule

// File: doc/cache_refill_controller.md
# cache_refill_controller

Fetches a 4-word cache line from main memory when the cache misses. Sits between the cache and main memory: it accepts a miss request with a 15-bit word address, issues four sequential single-word reads, collects the returned words into a line buffer, and presents the complete line to the cache with a one-cycle valid pulse. A watchdog aborts a refill whose memory responses stop arriving.

## Interface
Parameters:
- ADDR_W, 15, word-address width
- DATA_W, 32, word width
- TIMEOUT, 64, cycles allowed between consecutive memory responses before abort (≥ 2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- miss_req  in  1  cache requests a refill; sampled only when ready=1
- miss_addr  in  ADDR_W  any word address in the missing line
- ready  out  1  controller idle, can accept miss_req
- line_valid  out  1  one-cycle pulse: line_word0..3 and line_addr valid
- line_addr  out  ADDR_W  line-aligned address, {blk, 2'b00}
- line_word0..line_word3  out  DATA_W each  words at offsets 0..3
- refill_err  out  1  one-cycle pulse on timeout abort
- mm_rd  out  1  memory read strobe, one cycle per word
- mm_addr  out  ADDR_W  memory word address
- mm_rdata  in  DATA_W  memory read data
- mm_rvalid  in  1  mm_rdata valid this cycle

## Operation
- Reset values: ready=1; line_valid=0; refill_err=0; mm_rd=0; mm_addr=0; line_addr=0; line_word0..3=0; state IDLE; counters 0.
- States: IDLE, ISSUE, COLLECT, DONE.
- IDLE: ready=1. If miss_req, latch blk = miss_addr[14:2], clear issue_cnt, recv_cnt and watchdog, go to ISSUE. mm_rvalid is ignored in IDLE.
- ISSUE: mm_rd=1, mm_addr={blk, issue_cnt}. Issue one word per cycle for 4 cycles, offsets 0,1,2,3 in order, then go to COLLECT. Responses arriving during ISSUE are captured.
- COLLECT: on each mm_rvalid, write mm_rdata to line_word[recv_cnt] and increment recv_cnt. When the 4th word is captured, go to DONE. Responses are in request order.
- DONE: line_valid=1 for exactly one cycle, line_addr={blk,2'b00}, then return to IDLE. line_word* and line_addr hold until the next refill's first capture.
- Watchdog: in ISSUE and COLLECT, counts cycles since the last mm_rvalid, or since acceptance if no word has arrived yet. On reaching TIMEOUT it pulses refill_err for one cycle, moves to IDLE and does not assert line_valid. Partially written line_word* are then undefined.
- mm_rvalid beyond the 4th word of a refill is ignored.
- miss_req while ready=0 is neither queued nor acknowledged; the cache must hold or re-present it.

## Timing
- Accept on edge N (ready=1 and miss_req=1). mm_rd is high for edges N+1..N+4, with offsets 0..3.
- With memory latency L (rvalid L cycles after mm_rd), the last word is captured at N+4+L. line_valid is high in the cycle after that edge, and ready=1 the cycle after that.
- Minimum accept-to-line_valid latency is 5+L cycles.
- ready is low from the cycle after acceptance until the cycle after line_valid or refill_err.
- mm_rvalid and a watchdog expiry in the same cycle: the word is captured and the watchdog restarts. There is no error.
- rst mid-refill: next cycle all outputs return to reset values. No line_valid or refill_err is produced for the aborted refill.

## Structure
- Shared package: ADDR_W, DATA_W, WORDS_PER_LINE=4, OFFSET_W=2, state enum, line-address helper {blk, 2'b00}. The cache and main memory use the same constants.
- Sub-module: cache_line_buffer, a 4×DATA_W register file with write port (index, data, we) and four parallel read outputs. The FSM, issue/receive counters and watchdog stay in the top.

## Test plan
- Reset then idle: rst high 2 cycles → ready=1, mm_rd=0, line_valid=0, all words 0.
- Basic refill, L=1: miss_addr=1026 → mm_addr 1024,1025,1026,1027 on consecutive cycles; words 0xA0..0xA3 returned → line_valid one cycle, line_addr=1024, line_word0..3=0xA0..0xA3, 6 cycles after accept.
- Back-to-back: miss_req held high across two refills (1024 then 2047) → second accepted only the cycle ready returns. Second line_addr=2044; no request lost or doubled.
- Gapped responses: memory inserts 10-cycle gaps between words, TIMEOUT=64 → correct line and no refill_err. Stray rvalid in IDLE changes nothing.
- Timeout: memory returns 2 words then stops → refill_err pulses exactly at 64 cycles after the 2nd word, no line_valid, ready=1 the next cycle.
- Reset mid-COLLECT after 2 words → outputs at reset values next cycle, no line_valid. A new refill at 0x7FFC completes with line_addr=0x7FFC (top-of-memory wrap check).
